// File: rtl/ung_pkg.sv
// Shared types and derived constants for the parallel unary stream generator
// and the thermometer decoder it shares with the SNG lanes.
package ung_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } ung_state_e;

  // Beats per stream: NB = 2^WIDTH / P.
  function automatic int ung_nb(input int width, input int p);
    return (1 << width) / p;
  endfunction

  // Width of the beat index register: BEAT_W = WIDTH - log2(P).
  function automatic int ung_beat_w(input int width, input int p);
    return width - $clog2(p);
  endfunction

  // Legal when P is a power of two and 1 <= P < 2^WIDTH.
  function automatic bit ung_params_ok(input int width, input int p);
    return (p >= 1) && ((p & (p - 1)) == 0) && (p < (1 << width));
  endfunction

endpackage

// File: rtl/ung_par_stream_if.sv
// Input value handshake plus output beat stream of the unary generator.
interface ung_par_stream_if #(
  parameter int WIDTH = 5,
  parameter int P     = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [P-1:0]     out_bits;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bits, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bits, out_last
  );
endinterface

// File: rtl/ung_therm_dec.sv
// Combinational thermometer decoder: bit i of the beat is set while more
// than i ones remain, so the ones always form a contiguous prefix.
module ung_therm_dec #(
  parameter int WIDTH = 5,
  parameter int P     = 2
) (
  input  logic [WIDTH-1:0] rem_i,
  output logic [P-1:0]     bits_o
);

  always_comb begin
    // NOTE: default assignment first so no path leaves bits_o unassigned (no latch).
    bits_o = '0;
    for (int i = 0; i < P; i++) begin
      bits_o[i] = (rem_i > WIDTH'(i));
    end
  end

endmodule

// File: rtl/ung_par_stream.sv
// Parallel exact unary bit-stream generator: loads a WIDTH-bit value and emits
// its 2^WIDTH-bit thermometer stream, P bits per beat, under backpressure.
module ung_par_stream
  import ung_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int P     = 2,
  parameter int TRUNC = 0
) (
  input  logic             clk,
  input  logic             rst,
  ung_par_stream_if.slave  bus
);

  localparam int BEAT_W = ung_beat_w(WIDTH, P);
  localparam int NB     = ung_nb(WIDTH, P);
  localparam logic [WIDTH-1:0]  P_W       = WIDTH'(P);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  if (!ung_params_ok(WIDTH, P)) begin : g_bad_params
    $error("ung_par_stream: P must be a power of two below 2**WIDTH");
  end

  ung_state_e        state_q;
  logic [WIDTH-1:0]  rem_q;
  logic [BEAT_W-1:0] beat_q;

  logic             last_beat;
  logic             beat_acc;
  logic             stream_end;
  logic [WIDTH-1:0] rem_d;

  // Saturating decrement: the final partial beat drains rem to zero, never wraps.
  assign rem_d = (rem_q > P_W) ? (rem_q - P_W) : '0;

  assign last_beat = (TRUNC != 0) ? ((rem_q <= P_W) || (beat_q == LAST_BEAT))
                                  : (beat_q == LAST_BEAT);

  assign beat_acc   = (state_q == STREAM) && bus.out_ready;
  assign stream_end = beat_acc && last_beat;

  assign bus.out_valid = (state_q == STREAM);
  assign bus.out_last  = (state_q == STREAM) && last_beat;
  // Combinational out_ready -> in_ready path gives zero-bubble back-to-back streams.
  assign bus.in_ready  = (state_q == IDLE) || stream_end;

  ung_therm_dec #(
    .WIDTH (WIDTH),
    .P     (P)
  ) u_dec (
    .rem_i  (rem_q),
    .bits_o (bus.out_bits)
  );

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            rem_q   <= bus.in_data;
            beat_q  <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (beat_acc) begin
            rem_q  <= rem_d;
            beat_q <= beat_q + 1'b1;
            if (stream_end) begin
              if (bus.in_valid) begin
                rem_q  <= bus.in_data;
                beat_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ung_par_stream.sv
// Scoreboard bench: three generator configurations (P=2 fixed, P=4 fixed,
// P=2 truncated) share clk/rst; expected beats come from a reference model.
module tb_ung_par_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ung_par_stream_if #(.WIDTH(5), .P(2)) if0 ();
  ung_par_stream_if #(.WIDTH(5), .P(4)) if1 ();
  ung_par_stream_if #(.WIDTH(5), .P(2)) if2 ();

  ung_par_stream #(.WIDTH(5), .P(2), .TRUNC(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  ung_par_stream #(.WIDTH(5), .P(4), .TRUNC(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  ung_par_stream #(.WIDTH(5), .P(2), .TRUNC(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic       last;
    logic [3:0] bits;
  } beat_t;

  beat_t exp_q[$];
  int    vals_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic drive(input int sel, input bit iv, input logic [4:0] d, input bit ordy);
    case (sel)
      0: begin if0.in_valid = iv; if0.in_data = d; if0.out_ready = ordy; end
      1: begin if1.in_valid = iv; if1.in_data = d; if1.out_ready = ordy; end
      default: begin if2.in_valid = iv; if2.in_data = d; if2.out_ready = ordy; end
    endcase
  endtask

  task automatic sample(input int sel, output logic ov, output logic [3:0] bits,
                        output logic lst, output logic irdy);
    case (sel)
      0: begin ov = if0.out_valid; bits = {2'b00, if0.out_bits}; lst = if0.out_last; irdy = if0.in_ready; end
      1: begin ov = if1.out_valid; bits = if1.out_bits; lst = if1.out_last; irdy = if1.in_ready; end
      default: begin ov = if2.out_valid; bits = {2'b00, if2.out_bits}; lst = if2.out_last; irdy = if2.in_ready; end
    endcase
  endtask

  // Reference model: bit k of the stream is one iff k < v.
  function automatic int push_expected(input int sel, input int v);
    int    p;
    int    n;
    beat_t e;
    p = (sel == 1) ? 4 : 2;
    if (sel == 2) n = (v == 0) ? 1 : (v + p - 1) / p;
    else          n = 32 / p;
    for (int b = 0; b < n; b++) begin
      e.bits = '0;
      for (int i = 0; i < p; i++) e.bits[i] = ((b * p + i) < v);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
    return n;
  endfunction

  // Offers every value in vals_q back-to-back (in_valid held high) and
  // scoreboards each accepted beat; stall_pct sets the out_ready-low odds.
  task automatic run_stream(input int sel, input int stall_pct, input string name);
    int   pend[$];
    int   cycles, total_beats, ones, want_ones, active;
    logic ov, lst, irdy;
    logic [3:0] bits, prev_bits;
    logic prev_last;
    bit   iv, ordy, prev_stall, prev_acc_in, acc_in, acc_out, done;
    beat_t e;
    pend = vals_q;
    want_ones = 0;
    foreach (pend[k]) want_ones += pend[k];
    cycles = 0; total_beats = 0; ones = 0; active = 0;
    prev_stall = 0; prev_acc_in = 0; done = 0;
    prev_bits = '0; prev_last = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    iv   = (pend.size() != 0);
    ordy = ($urandom_range(99) >= stall_pct);
    drive(sel, iv, iv ? 5'(pend[0]) : 5'd0, ordy);
    while (!done) begin
      @(negedge clk);
      sample(sel, ov, bits, lst, irdy);
      if (prev_acc_in) begin
        n_cmp++;
        if (ov !== 1'b1) begin
          n_bad++;
          $display("FAIL %s latency: out_valid=%b required 1 after load", name, ov);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (ov !== 1'b1 || bits !== prev_bits || lst !== prev_last) begin
          n_bad++;
          $display("FAIL %s stall_hold: valid=%b bits=%b last=%b required 1/%b/%b",
                   name, ov, bits, lst, prev_bits, prev_last);
        end
      end
      if (ov === 1'b1) active++;
      acc_out = (ov === 1'b1) && ordy;
      acc_in  = iv && (irdy === 1'b1);
      if (acc_out) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra_beat: bits=%b last=%b required no beat", name, bits, lst);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          ones += $countones(bits);
          if ({lst, bits} !== {e.last, e.bits}) begin
            n_bad++;
            $display("FAIL %s beat: bits=%b last=%b required bits=%b last=%b",
                     name, bits, lst, e.bits, e.last);
          end
        end
      end
      if (acc_in) total_beats += push_expected(sel, pend.pop_front());
      prev_acc_in = acc_in;
      prev_stall  = (ov === 1'b1) && !ordy;
      prev_bits   = bits;
      prev_last   = lst;
      if (pend.size() == 0 && exp_q.size() == 0 && !acc_in) done = 1;
      cycles++;
      if (!done && cycles > 600) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: %0d beats outstanding required 0", name, exp_q.size());
        done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
        iv   = (pend.size() != 0);
        ordy = ($urandom_range(99) >= stall_pct);
        drive(sel, iv, iv ? 5'(pend[0]) : 5'd0, ordy);
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    sample(sel, ov, bits, lst, irdy);
    n_cmp++;
    if (irdy !== 1'b1 || ov !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: in_ready=%b out_valid=%b required 1/0", name, irdy, ov);
    end
    n_cmp++;
    if (ones != want_ones) begin
      n_bad++;
      $display("FAIL %s ones_total: %0d required %0d", name, ones, want_ones);
    end
    if (stall_pct == 0) begin
      n_cmp++;
      if (active != total_beats) begin
        n_bad++;
        $display("FAIL %s valid_cycles: %0d required %0d", name, active, total_beats);
      end
    end
  endtask

  task automatic test_reset();
    logic ov, lst, irdy;
    logic [3:0] bits;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sample(s, ov, bits, lst, irdy);
      n_cmp++;
      if (ov !== 1'b0 || bits !== 4'b0 || lst !== 1'b0 || irdy !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: valid=%b bits=%b last=%b ready=%b required 0/0000/0/1",
                 s, ov, bits, lst, irdy);
      end
    end
  endtask

  task automatic test_fixed_len();
    vals_q = '{5};  run_stream(0, 0, "p2_v5");
    vals_q = '{31}; run_stream(0, 0, "p2_v31");
    vals_q = '{31}; run_stream(1, 0, "p4_v31");
    vals_q = '{0};  run_stream(1, 0, "p4_v0");
  endtask

  task automatic test_trunc();
    vals_q = '{0};  run_stream(2, 0, "trunc_v0");
    vals_q = '{6};  run_stream(2, 0, "trunc_v6");
    vals_q = '{31}; run_stream(2, 0, "trunc_v31");
  endtask

  task automatic test_stall();
    vals_q = '{9};      run_stream(0, 50, "stall_p2_v9");
    vals_q = '{9};      run_stream(2, 50, "stall_trunc_v9");
    vals_q = '{17, 4};  run_stream(1, 40, "stall_p4_pair");
  endtask

  task automatic test_back_to_back();
    vals_q = '{7, 20, 1};     run_stream(0, 0, "b2b_p2");
    vals_q = '{3, 0, 12, 31}; run_stream(2, 0, "b2b_trunc");
  endtask

  task automatic test_reset_abort();
    logic ov, lst, irdy;
    logic [3:0] bits;
    @(posedge clk); #1;
    drive(0, 1'b1, 5'd20, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 5'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    sample(0, ov, bits, lst, irdy);
    n_cmp++;
    if (ov !== 1'b1 || bits !== 4'b0011 || lst !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_beat4: valid=%b bits=%b last=%b required 1/0011/0", ov, bits, lst);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    sample(0, ov, bits, lst, irdy);
    n_cmp++;
    if (ov !== 1'b0 || irdy !== 1'b1 || lst !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: valid=%b ready=%b last=%b required 0/1/0", ov, irdy, lst);
    end
    vals_q = '{3}; run_stream(0, 0, "after_abort_v3");
  endtask

  initial begin
    test_reset();
    test_fixed_len();
    test_trunc();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
